// File: rtl/eth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : eth_pkg                                                        |
// | Brief   : RMII receive constants and the preamble/SFD state encoding      |
// |           shared by the eth_rx_bitorder front end.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package eth_pkg;

    // Preamble dibit as it appears on RMII RXD[1:0] (0x55 sent LSB first)
    localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
    // Final dibit of the SFD (0xD5 sent LSB first ends in 2'b11)
    localparam logic [1:0]  SFD_DIBIT       = 2'b11;
    // Preamble plus SFD length in dibits: 31 x PREAMBLE_DIBIT then SFD_DIBIT
    localparam int unsigned PREAMBLE_DIBITS = 32;
    // Dibits that make up one byte on the RMII wire
    localparam int unsigned DIBITS_PER_BYTE = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        BAD      = 2'd3
    } rx_state_t;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_dibit_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : eth_dibit_reorder                                              |
// | Brief   : Reorders a stream of RMII payload dibits from wire order        |
// |           (LSB-first per byte) to MSB-first per byte.                     |
// |   clk    in  clock                                                       |
// |   rst    in  synchronous active-high reset                               |
// |   axiiv  in  input dibit valid                                           |
// |   axiid  in  input dibit, wire order                                     |
// |   axiov  out output dibit valid (registered)                             |
// |   axiod  out output dibit, MSB-first within each byte (registered)       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module eth_dibit_reorder
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam logic [1:0] c_last_pos = 2'(DIBITS_PER_BYTE - 1);

    // Position of the next incoming dibit within its byte
    logic [1:0]      r_cnt,     w_cnt_d;
    // Wire dibits 0..2 of the byte being collected (bits 1:0, 3:2, 5:4)
    logic [2:0][1:0] r_collect, w_collect_d;
    // Completed byte awaiting output of its lower three dibits
    logic [2:0][1:0] r_emit,    w_emit_d;
    // Emit dibits still to be sent; the next one out is r_emit[r_rem-1]
    logic [1:0]      r_rem,     w_rem_d;
    logic            r_axiov,   w_axiov_d;
    logic [1:0]      r_axiod,   w_axiod_d;

    always_comb begin
        w_cnt_d     = r_cnt;
        w_collect_d = r_collect;
        w_emit_d    = r_emit;
        w_rem_d     = r_rem;
        w_axiov_d   = 1'b0;
        w_axiod_d   = r_axiod;

        // Drain the previously completed byte, top dibit first
        if (r_rem != 2'd0) begin
            w_axiov_d = 1'b1;
            w_axiod_d = r_emit[r_rem - 2'd1];
            w_rem_d   = r_rem - 2'd1;
        end

        if (axiiv) begin
            if (r_cnt == c_last_pos) begin
                // Bits 7:6 go straight out; the drain above is always
                // finished by now since a byte takes four cycles to collect.
                w_axiov_d = 1'b1;
                w_axiod_d = axiid;
                w_emit_d  = r_collect;
                w_rem_d   = 2'd3;
                w_cnt_d   = 2'd0;
            end else begin
                w_collect_d[r_cnt] = axiid;
                w_cnt_d            = r_cnt + 2'd1;
            end
        end else begin
            // Valid dropped: any partially collected byte is discarded
            w_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_collect <= '0;
            r_emit    <= '0;
            r_rem     <= 2'd0;
            r_axiov   <= 1'b0;
            r_axiod   <= 2'b00;
        end else begin
            r_cnt     <= w_cnt_d;
            r_collect <= w_collect_d;
            r_emit    <= w_emit_d;
            r_rem     <= w_rem_d;
            r_axiov   <= w_axiov_d;
            r_axiod   <= w_axiod_d;
        end
    end

    assign axiov = r_axiov;
    assign axiod = r_axiod;

endmodule : eth_dibit_reorder
`default_nettype wire

// File: rtl/eth_rx_bitorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : eth_rx_bitorder                                                |
// | Brief   : RMII receive front end. Validates and strips preamble + SFD,   |
// |           forwards payload dibits (FCS included) reordered MSB-first     |
// |           per byte, and drives the PHY reset pin.                        |
// |   clk       in  50 MHz RMII reference clock                              |
// |   rst       in  synchronous active-high reset                            |
// |   eth_crsdv in  RMII carrier-sense / data-valid                          |
// |   eth_rxd   in  RMII receive dibit                                       |
// |   eth_rstn  out PHY reset, active low (combinational ~rst)               |
// |   axiov     out output dibit valid                                       |
// |   axiod     out output dibit, MSB-first within each byte                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module eth_rx_bitorder
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_DIBITS = eth_pkg::PREAMBLE_DIBITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eth_crsdv,
    input  logic [1:0] eth_rxd,
    output logic       eth_rstn,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam int unsigned   c_cnt_w    = $clog2(PREAMBLE_DIBITS);
    // Count value at which the SFD dibit is expected
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PREAMBLE_DIBITS - 1);

    rx_state_t          r_state, w_state_d;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_d;
    logic               r_s_v,   w_s_v_d;
    logic [1:0]         r_s_d,   w_s_d_d;

    assign eth_rstn = ~rst;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        w_s_v_d   = 1'b0;
        w_s_d_d   = r_s_d;

        case (r_state)
            IDLE: begin
                if (eth_crsdv) begin
                    if (eth_rxd == PREAMBLE_DIBIT) begin
                        w_state_d = PREAMBLE;
                        w_cnt_d   = c_cnt_w'(1);
                    end else begin
                        w_state_d = BAD;
                    end
                end
            end
            PREAMBLE: begin
                if (!eth_crsdv) begin
                    w_state_d = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_d = (eth_rxd == SFD_DIBIT) ? DATA : BAD;
                end else if (eth_rxd == PREAMBLE_DIBIT) begin
                    w_cnt_d = r_cnt + c_cnt_w'(1);
                end else begin
                    w_state_d = BAD;
                end
            end
            DATA: begin
                if (eth_crsdv) begin
                    w_s_v_d = 1'b1;
                    w_s_d_d = eth_rxd;
                end else begin
                    w_state_d = IDLE;
                end
            end
            BAD: begin
                // Ignore the rest of the burst; resync on carrier drop
                if (!eth_crsdv) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s_v   <= 1'b0;
            r_s_d   <= 2'b00;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_s_v   <= w_s_v_d;
            r_s_d   <= w_s_d_d;
        end
    end

    eth_dibit_reorder u_reorder (
        .clk   (clk),
        .rst   (rst),
        .axiiv (r_s_v),
        .axiid (r_s_d),
        .axiov (axiov),
        .axiod (axiod)
    );

endmodule : eth_rx_bitorder
`default_nettype wire

// File: tb/tb_eth_rx_bitorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_eth_rx_bitorder                                             |
// | Brief   : Self-checking bench for eth_rx_bitorder: a per-cycle vector    |
// |           table of RMII inputs with expected outputs, followed by a      |
// |           hand-written mid-frame reset sequence.                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_eth_rx_bitorder;

    logic       clk = 1'b0;
    logic       rst;
    logic       eth_crsdv;
    logic [1:0] eth_rxd;
    logic       eth_rstn;
    logic       axiov;
    logic [1:0] axiod;

    always #10 clk = ~clk;

    eth_rx_bitorder #(.PREAMBLE_DIBITS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .eth_crsdv (eth_crsdv),
        .eth_rxd   (eth_rxd),
        .eth_rstn  (eth_rstn),
        .axiov     (axiov),
        .axiod     (axiod)
    );

    // One record per clock: inputs sampled at that edge, and the outputs
    // expected just after that same edge.
    typedef struct packed {
        logic       crsdv;
        logic [1:0] rxd;
        logic       exp_v;
        logic [1:0] exp_d;
    } vec_t;

    localparam int c_max_vec = 1024;

    vec_t vecs [c_max_vec];
    int   n_vec;
    int   tests;
    int   fails;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input logic c, input logic [1:0] d);
        vecs[n_vec].crsdv = c;
        vecs[n_vec].rxd   = d;
        n_vec++;
    endtask

    task automatic put_idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 2'b00);
    endtask

    task automatic put_preamble();
        for (int i = 0; i < 31; i++) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
    endtask

    // A byte goes onto the wire LSB dibit first. Its bits 7:6 appear one
    // record after the record carrying its 4th dibit (two edges after that
    // dibit is on the wire), followed by 5:4, 3:2, 1:0.
    task automatic put_byte(input logic [7:0] b);
        int j;
        for (int i = 0; i < 4; i++) put(1'b1, b[2*i +: 2]);
        j = n_vec - 1;
        for (int k = 1; k <= 4; k++) begin
            vecs[j+k].exp_v = 1'b1;
            vecs[j+k].exp_d = b[8-2*k +: 2];
        end
    endtask

    // Drive one cycle directly and wait until just after its edge
    task automatic drive(input logic r, input logic c, input logic [1:0] d);
        rst       = r;
        eth_crsdv = c;
        eth_rxd   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] stream [10];
        tests = 0;
        fails = 0;
        n_vec = 0;
        for (int i = 0; i < c_max_vec; i++) vecs[i] = '0;

        // ---------------- reset state ----------------
        rst       = 1'b1;
        eth_crsdv = 1'b0;
        eth_rxd   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_axiov", int'(axiov), 0);
        check("reset_axiod", int'(axiod), 0);
        check("reset_rstn_low", int'(eth_rstn), 0);
        rst = 1'b0;
        #1;
        check("rstn_high", int'(eth_rstn), 1);

        // ---------------- vector table ----------------
        // Single byte 0xB4: wire 00,01,11,10 -> out 10,11,01,00
        put_idle(2);
        put_preamble();
        put_byte(8'hB4);
        put_idle(6);

        // Ten back-to-back bytes: continuous 40-cycle valid
        stream = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'h00, 8'h00, 8'h01, 8'h00};
        put_preamble();
        for (int i = 0; i < 10; i++) put_byte(stream[i]);
        put_idle(6);

        // Corrupt preamble (10 at position 12): whole burst ignored
        put_preamble();
        vecs[n_vec-32+12].rxd = 2'b10;
        for (int i = 0; i < 8; i++) put(1'b1, 2'b11);
        put_idle(3);
        put_preamble();
        put_byte(8'hA5);
        put_idle(6);

        // Missing SFD (32nd dibit is 01): no output, then recovery
        for (int i = 0; i < 32; i++) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
        for (int i = 0; i < 8; i++) put(1'b1, 2'b10);
        put_idle(3);
        put_preamble();
        put_byte(8'h3C);
        put_idle(6);

        // Six payload dibits: one byte out, trailing two dropped
        put_preamble();
        put_byte(8'h5A);
        put(1'b1, 2'b11);
        put(1'b1, 2'b10);
        put_idle(8);

        for (int i = 0; i < n_vec; i++) begin
            drive(1'b0, vecs[i].crsdv, vecs[i].rxd);
            check($sformatf("vec%0d_axiov", i), int'(axiov), int'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                check($sformatf("vec%0d_axiod", i), int'(axiod), int'(vecs[i].exp_d));
        end

        // ---------------- reset mid-payload ----------------
        for (int i = 0; i < 31; i++) drive(1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b1, 2'b11);
        // Byte 0x12 on the wire: 10,00,01,00
        drive(1'b0, 1'b1, 2'b10);
        drive(1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b1, 2'b11);
        check("rstseq_b76_v", int'(axiov), 1);
        check("rstseq_b76_d", int'(axiod), 0);
        drive(1'b0, 1'b1, 2'b10);
        check("rstseq_b54_v", int'(axiov), 1);
        check("rstseq_b54_d", int'(axiod), 1);
        drive(1'b1, 1'b1, 2'b10);
        check("rstseq_abort_v", int'(axiov), 0);
        check("rstseq_rstn", int'(eth_rstn), 0);
        drive(1'b1, 1'b1, 2'b11);
        check("rstseq_hold_v", int'(axiov), 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b11);
            check($sformatf("rstseq_post%0d_v", i), int'(axiov), 0);
        end
        check("rstseq_rstn_back", int'(eth_rstn), 1);
        drive(1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 2'b00);

        // Fresh frame after the aborted one: byte 0x6C, wire 00,11,10,01
        for (int i = 0; i < 31; i++) drive(1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b1, 2'b11);
        drive(1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b1, 2'b11);
        drive(1'b0, 1'b1, 2'b10);
        drive(1'b0, 1'b1, 2'b01);
        check("fresh_pre_v", int'(axiov), 0);
        drive(1'b0, 1'b0, 2'b00);
        check("fresh_d0_v", int'(axiov), 1);
        check("fresh_d0", int'(axiod), 1);
        drive(1'b0, 1'b0, 2'b00);
        check("fresh_d1", int'(axiod), 2);
        drive(1'b0, 1'b0, 2'b00);
        check("fresh_d2", int'(axiod), 3);
        drive(1'b0, 1'b0, 2'b00);
        check("fresh_d3_v", int'(axiov), 1);
        check("fresh_d3", int'(axiod), 0);
        drive(1'b0, 1'b0, 2'b00);
        check("fresh_end_v", int'(axiov), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_eth_rx_bitorder
`default_nettype wire
